// File: rtl/operand_fetch_stage.sv
// ID->EX operand stage: operand forwarding, load-use stall control and the ID/EX register.
// Optional hazard counters (stat_stalls / stat_fwds) are built when HAZARD_STATS_EN is defined.
module operand_fetch_stage #(
    parameter int CTRL_W            = 12,
    parameter int LOAD_STALL_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [2:0]        in_rs1,
    input  logic [2:0]        in_rs2,
    input  logic [2:0]        in_rd,
    input  logic              in_use_rs1,
    input  logic              in_use_rs2,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [15:0]       in_imm,
    input  logic [15:0]       in_pc,
    output logic [2:0]        rf_ra,
    output logic [2:0]        rf_rb,
    input  logic [15:0]       rf_busa,
    input  logic [15:0]       rf_busb,
    input  logic              ex_wr_en,
    input  logic              ex_is_load,
    input  logic [2:0]        ex_rd,
    input  logic [15:0]       ex_result,
    input  logic              mem_wr_en,
    input  logic [2:0]        mem_rd,
    input  logic [15:0]       mem_result,
    input  logic              wb_wr_en,
    input  logic [2:0]        wb_rd,
    input  logic [15:0]       wb_result,
    input  logic              flush,
    input  logic              hold,
    output logic              stall,
    output logic              out_valid,
    output logic [15:0]       out_a,
    output logic [15:0]       out_b,
    output logic [15:0]       out_imm,
    output logic [15:0]       out_pc,
    output logic [2:0]        out_rd,
    output logic [CTRL_W-1:0] out_ctrl
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0]       stat_stalls,
    output logic [15:0]       stat_fwds
`endif
);
    // state    | meaning
    // ST_RUN   | accepting instructions; a load-use hazard inserts the first bubble here
    // ST_STALL | inserting the remaining load-use bubbles, r_cnt = bubbles still to go
    typedef enum logic {ST_RUN, ST_STALL} state_t;

    localparam int LSC_CLAMP = (LOAD_STALL_CYCLES < 1) ? 1 :
                               (LOAD_STALL_CYCLES > 7) ? 7 : LOAD_STALL_CYCLES;
    localparam logic [2:0] CNT_INIT = 3'(LSC_CLAMP - 1);

    state_t            r_state, w_state_nxt;
    logic [2:0]        r_cnt, w_cnt_nxt;
    logic              w_accept, w_bubble, w_ld_bubble;
    logic              r_out_valid;
    logic [15:0]       r_out_a, r_out_b, r_out_imm, r_out_pc;
    logic [2:0]        r_out_rd;
    logic [CTRL_W-1:0] r_out_ctrl;

    logic w_a_zero, w_a_ex, w_a_mem, w_a_wb, w_fwd_a;
    logic w_b_zero, w_b_ex, w_b_mem, w_b_wb, w_fwd_b;
    logic [15:0] w_opnd_a, w_opnd_b;
    logic w_hz;

    assign rf_ra = in_rs1;
    assign rf_rb = in_rs2;

    // A load in EX has no data yet, so it never forwards; youngest writer wins.
    assign w_a_zero = (in_rs1 == 3'd0);
    assign w_a_ex   = ex_wr_en && !ex_is_load && (ex_rd == in_rs1);
    assign w_a_mem  = mem_wr_en && (mem_rd == in_rs1);
    assign w_a_wb   = wb_wr_en && (wb_rd == in_rs1);
    assign w_opnd_a = w_a_zero ? 16'h0000 : w_a_ex ? ex_result :
                      w_a_mem ? mem_result : w_a_wb ? wb_result : rf_busa;
    assign w_fwd_a  = in_use_rs1 && !w_a_zero && (w_a_ex || w_a_mem || w_a_wb);

    assign w_b_zero = (in_rs2 == 3'd0);
    assign w_b_ex   = ex_wr_en && !ex_is_load && (ex_rd == in_rs2);
    assign w_b_mem  = mem_wr_en && (mem_rd == in_rs2);
    assign w_b_wb   = wb_wr_en && (wb_rd == in_rs2);
    assign w_opnd_b = w_b_zero ? 16'h0000 : w_b_ex ? ex_result :
                      w_b_mem ? mem_result : w_b_wb ? wb_result : rf_busb;
    assign w_fwd_b  = in_use_rs2 && !w_b_zero && (w_b_ex || w_b_mem || w_b_wb);

    assign w_hz = in_valid && ex_is_load && ex_wr_en && (ex_rd != 3'd0) &&
                  ((in_use_rs1 && (ex_rd == in_rs1)) || (in_use_rs2 && (ex_rd == in_rs2)));

    assign stall = reset && !flush &&
                   (hold || (r_state == ST_STALL) || ((r_state == ST_RUN) && w_hz));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_bubble    = 1'b0;
        w_ld_bubble = 1'b0;
        if (flush) begin
            w_bubble    = 1'b1;
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = 3'd0;
        end else if (!hold) begin
            if (r_state == ST_STALL) begin
                w_bubble    = 1'b1;
                w_ld_bubble = 1'b1;
                w_cnt_nxt   = r_cnt - 3'd1;
                if (r_cnt == 3'd1) w_state_nxt = ST_RUN;
            end else if (w_hz) begin
                // The hazard cycle itself is the first of LSC_CLAMP bubbles.
                w_bubble    = 1'b1;
                w_ld_bubble = 1'b1;
                w_cnt_nxt   = CNT_INIT;
                w_state_nxt = (CNT_INIT == 3'd0) ? ST_RUN : ST_STALL;
            end else if (in_valid) begin
                w_accept = 1'b1;
            end else begin
                w_bubble = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_RUN;
            r_cnt       <= 3'd0;
            r_out_valid <= 1'b0;
            r_out_a     <= 16'h0000;
            r_out_b     <= 16'h0000;
            r_out_imm   <= 16'h0000;
            r_out_pc    <= 16'h0000;
            r_out_rd    <= 3'd0;
            r_out_ctrl  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_a     <= w_opnd_a;
                r_out_b     <= w_opnd_b;
                r_out_imm   <= in_imm;
                r_out_pc    <= in_pc;
                r_out_rd    <= in_rd;
                r_out_ctrl  <= in_ctrl;
            end else if (w_bubble) begin
                r_out_valid <= 1'b0;
                r_out_a     <= 16'h0000;
                r_out_b     <= 16'h0000;
                r_out_imm   <= 16'h0000;
                r_out_pc    <= 16'h0000;
                r_out_rd    <= 3'd0;
                r_out_ctrl  <= '0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_a     = r_out_a;
    assign out_b     = r_out_b;
    assign out_imm   = r_out_imm;
    assign out_pc    = r_out_pc;
    assign out_rd    = r_out_rd;
    assign out_ctrl  = r_out_ctrl;

`ifdef HAZARD_STATS_EN
    logic [15:0] r_stat_stalls, r_stat_fwds;

    // w_ld_bubble and w_accept are already low under hold or flush.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stat_stalls <= 16'h0000;
            r_stat_fwds   <= 16'h0000;
        end else begin
            if (w_ld_bubble && (r_stat_stalls != 16'hFFFF))
                r_stat_stalls <= r_stat_stalls + 16'd1;
            if (w_accept && (w_fwd_a || w_fwd_b) && (r_stat_fwds != 16'hFFFF))
                r_stat_fwds <= r_stat_fwds + 16'd1;
        end
    end

    assign stat_stalls = r_stat_stalls;
    assign stat_fwds   = r_stat_fwds;
`endif
endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: two instances (1 and 3 load-use bubbles) share stimulus and
// are compared every cycle against a cycle-level reference model, plus directed corner cases.
module tb_operand_fetch_stage;
    localparam int CW = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, in_valid, in_use_rs1, in_use_rs2;
    logic [2:0]    in_rs1, in_rs2, in_rd;
    logic [CW-1:0] in_ctrl;
    logic [15:0]   in_imm, in_pc, rf_busa, rf_busb;
    logic          ex_wr_en, ex_is_load, mem_wr_en, wb_wr_en, flush, hold;
    logic [2:0]    ex_rd, mem_rd, wb_rd;
    logic [15:0]   ex_result, mem_result, wb_result;

    logic [2:0]    ra[2], rb[2], ord[2];
    logic          st[2], ov[2];
    logic [15:0]   oa[2], ob[2], oimm[2], opc[2];
    logic [CW-1:0] octl[2];
`ifdef HAZARD_STATS_EN
    logic [15:0]   s_stl[2], s_fwd[2];
`endif

    operand_fetch_stage #(.CTRL_W(CW), .LOAD_STALL_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_rd(in_rd), .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2), .in_ctrl(in_ctrl),
        .in_imm(in_imm), .in_pc(in_pc), .rf_ra(ra[0]), .rf_rb(rb[0]), .rf_busa(rf_busa),
        .rf_busb(rf_busb), .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .ex_result(ex_result), .mem_wr_en(mem_wr_en), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .wb_result(wb_result), .flush(flush), .hold(hold),
        .stall(st[0]), .out_valid(ov[0]), .out_a(oa[0]), .out_b(ob[0]), .out_imm(oimm[0]),
        .out_pc(opc[0]), .out_rd(ord[0]), .out_ctrl(octl[0])
`ifdef HAZARD_STATS_EN
        , .stat_stalls(s_stl[0]), .stat_fwds(s_fwd[0])
`endif
    );

    operand_fetch_stage #(.CTRL_W(CW), .LOAD_STALL_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_rd(in_rd), .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2), .in_ctrl(in_ctrl),
        .in_imm(in_imm), .in_pc(in_pc), .rf_ra(ra[1]), .rf_rb(rb[1]), .rf_busa(rf_busa),
        .rf_busb(rf_busb), .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .ex_result(ex_result), .mem_wr_en(mem_wr_en), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .wb_result(wb_result), .flush(flush), .hold(hold),
        .stall(st[1]), .out_valid(ov[1]), .out_a(oa[1]), .out_b(ob[1]), .out_imm(oimm[1]),
        .out_pc(opc[1]), .out_rd(ord[1]), .out_ctrl(octl[1])
`ifdef HAZARD_STATS_EN
        , .stat_stalls(s_stl[1]), .stat_fwds(s_fwd[1])
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state per instance: remaining bubbles and the expected ID/EX contents.
    int            m_pend[2];
    logic          m_v[2];
    logic [15:0]   m_a[2], m_b[2], m_imm[2], m_pc[2];
    logic [2:0]    m_rd[2];
    logic [CW-1:0] m_ctrl[2];
    int            m_sst[2], m_sfw[2];

    function automatic int lsc(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Writers listed oldest to youngest, so a later match overrides an earlier one.
    function automatic logic [15:0] ref_opnd(input logic [2:0] s, input logic [15:0] rf,
                                             output bit fw);
        logic [15:0] v;
        v = rf;
        fw = 1'b0;
        if (wb_wr_en && wb_rd == s)                 begin v = wb_result;  fw = 1'b1; end
        if (mem_wr_en && mem_rd == s)               begin v = mem_result; fw = 1'b1; end
        if (ex_wr_en && !ex_is_load && ex_rd == s)  begin v = ex_result;  fw = 1'b1; end
        if (s == 3'd0)                              begin v = 16'h0000;   fw = 1'b0; end
        return v;
    endfunction

    function automatic bit ref_hz();
        return in_valid && ex_is_load && ex_wr_en && ex_rd != 3'd0 &&
               ((in_use_rs1 && ex_rd == in_rs1) || (in_use_rs2 && ex_rd == in_rs2));
    endfunction

    function automatic int sat(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    task automatic m_bubble(input int i);
        m_v[i] = 1'b0; m_a[i] = '0; m_b[i] = '0; m_imm[i] = '0; m_pc[i] = '0;
        m_rd[i] = '0; m_ctrl[i] = '0;
    endtask

    task automatic model_edge();
        bit fa, fb, hz;
        logic [15:0] a, b;
        a  = ref_opnd(in_rs1, rf_busa, fa);
        b  = ref_opnd(in_rs2, rf_busb, fb);
        hz = ref_hz();
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                m_bubble(i); m_pend[i] = 0; m_sst[i] = 0; m_sfw[i] = 0;
            end else if (flush) begin
                m_bubble(i); m_pend[i] = 0;
            end else if (hold) begin
                m_pend[i] = m_pend[i];
            end else if (m_pend[i] > 0) begin
                m_bubble(i); m_pend[i]--; m_sst[i] = sat(m_sst[i]);
            end else if (hz) begin
                m_bubble(i); m_pend[i] = lsc(i) - 1; m_sst[i] = sat(m_sst[i]);
            end else if (in_valid) begin
                m_v[i] = 1'b1; m_a[i] = a; m_b[i] = b; m_imm[i] = in_imm; m_pc[i] = in_pc;
                m_rd[i] = in_rd; m_ctrl[i] = in_ctrl;
                if ((fa && in_use_rs1) || (fb && in_use_rs2)) m_sfw[i] = sat(m_sfw[i]);
            end else begin
                m_bubble(i);
            end
        end
    endtask

    // One clock: check combinational outputs, advance the model, check registered outputs.
    task automatic step();
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("stall[%0d]", i), 32'(st[i]),
                32'(reset && !flush && (hold || m_pend[i] > 0 || ref_hz())));
            chk($sformatf("rf_ra[%0d]", i), 32'(ra[i]), 32'(in_rs1));
            chk($sformatf("rf_rb[%0d]", i), 32'(rb[i]), 32'(in_rs2));
        end
        model_edge();
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("out_valid[%0d]", i), 32'(ov[i]), 32'(m_v[i]));
            chk($sformatf("out_a[%0d]", i), 32'(oa[i]), 32'(m_a[i]));
            chk($sformatf("out_b[%0d]", i), 32'(ob[i]), 32'(m_b[i]));
            chk($sformatf("out_imm[%0d]", i), 32'(oimm[i]), 32'(m_imm[i]));
            chk($sformatf("out_pc[%0d]", i), 32'(opc[i]), 32'(m_pc[i]));
            chk($sformatf("out_rd[%0d]", i), 32'(ord[i]), 32'(m_rd[i]));
            chk($sformatf("out_ctrl[%0d]", i), 32'(octl[i]), 32'(m_ctrl[i]));
`ifdef HAZARD_STATS_EN
            chk($sformatf("stat_stalls[%0d]", i), 32'(s_stl[i]), 32'(m_sst[i]));
            chk($sformatf("stat_fwds[%0d]", i), 32'(s_fwd[i]), 32'(m_sfw[i]));
`endif
        end
    endtask

    task automatic clear_in();
        reset = 1'b1; in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
        in_use_rs1 = 1'b0; in_use_rs2 = 1'b0; in_ctrl = '0; in_imm = '0; in_pc = '0;
        rf_busa = '0; rf_busb = '0; ex_wr_en = 1'b0; ex_is_load = 1'b0; ex_rd = '0;
        ex_result = '0; mem_wr_en = 1'b0; mem_rd = '0; mem_result = '0; wb_wr_en = 1'b0;
        wb_rd = '0; wb_result = '0; flush = 1'b0; hold = 1'b0;
    endtask

    task automatic do_reset();
        clear_in();
        reset = 1'b0;
        hold  = 1'b1;   // stall must still read 0 while reset is low
        step();
        hold  = 1'b0;
        step();
        reset = 1'b1;
    endtask

    // Load in EX writing r2 while the decoded instruction reads r2.
    task automatic set_load_use();
        in_valid = 1'b1; in_rs1 = 3'd1; in_rs2 = 3'd2; in_use_rs1 = 1'b1; in_use_rs2 = 1'b1;
        in_rd = 3'd4; in_pc = 16'h0040; in_ctrl = 12'h5C3;
        ex_wr_en = 1'b1; ex_is_load = 1'b1; ex_rd = 3'd2; ex_result = 16'hDEAD;
    endtask

    typedef struct {
        logic [2:0] rs1, rs2;
        logic [15:0] busa, busb;
        logic ex_wr; logic [2:0] ex_rd; logic [15:0] ex_res;
        logic mem_wr; logic [2:0] mem_rd; logic [15:0] mem_res;
        logic wb_wr; logic [2:0] wb_rd; logic [15:0] wb_res;
        logic [15:0] exp_a, exp_b;
    } vec_t;

    vec_t vt[7];
    int nst[2], nbub[2];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{3'd1, 3'd2, 16'h1234, 16'h00FF, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000,
                  1'b0, 3'd0, 16'h0000, 16'h1234, 16'h00FF};
        vt[1] = '{3'd3, 3'd0, 16'h1111, 16'h2222, 1'b1, 3'd3, 16'hAAAA, 1'b1, 3'd3, 16'hBBBB,
                  1'b1, 3'd3, 16'hCCCC, 16'hAAAA, 16'h0000};
        vt[2] = '{3'd3, 3'd0, 16'h1111, 16'h2222, 1'b0, 3'd3, 16'hAAAA, 1'b1, 3'd3, 16'hBBBB,
                  1'b1, 3'd3, 16'hCCCC, 16'hBBBB, 16'h0000};
        vt[3] = '{3'd3, 3'd0, 16'h1111, 16'h2222, 1'b0, 3'd3, 16'hAAAA, 1'b0, 3'd3, 16'hBBBB,
                  1'b1, 3'd3, 16'hCCCC, 16'hCCCC, 16'h0000};
        vt[4] = '{3'd0, 3'd0, 16'hFFFF, 16'hFFFF, 1'b1, 3'd0, 16'hAAAA, 1'b1, 3'd0, 16'hBBBB,
                  1'b1, 3'd0, 16'hCCCC, 16'h0000, 16'h0000};
        vt[5] = '{3'd5, 3'd5, 16'h1111, 16'h2222, 1'b1, 3'd4, 16'hAAAA, 1'b1, 3'd5, 16'hBBBB,
                  1'b0, 3'd0, 16'h0000, 16'hBBBB, 16'hBBBB};
        vt[6] = '{3'd7, 3'd6, 16'h7777, 16'h6666, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000,
                  1'b1, 3'd6, 16'hCCCC, 16'h7777, 16'hCCCC};

        do_reset();
        for (int i = 0; i < 2; i++) chk($sformatf("reset_valid[%0d]", i), 32'(ov[i]), 32'd0);

        // Forwarding table
        for (int k = 0; k < 7; k++) begin
            clear_in();
            in_valid = 1'b1; in_use_rs1 = 1'b1; in_use_rs2 = 1'b1;
            in_rd = 3'(k); in_pc = 16'(16'h0100 + k); in_imm = 16'h0F0F; in_ctrl = 12'(k + 1);
            in_rs1 = vt[k].rs1; in_rs2 = vt[k].rs2; rf_busa = vt[k].busa; rf_busb = vt[k].busb;
            ex_wr_en = vt[k].ex_wr; ex_rd = vt[k].ex_rd; ex_result = vt[k].ex_res;
            mem_wr_en = vt[k].mem_wr; mem_rd = vt[k].mem_rd; mem_result = vt[k].mem_res;
            wb_wr_en = vt[k].wb_wr; wb_rd = vt[k].wb_rd; wb_result = vt[k].wb_res;
            step();
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("vec%0d_a[%0d]", k, i), 32'(oa[i]), 32'(vt[k].exp_a));
                chk($sformatf("vec%0d_b[%0d]", k, i), 32'(ob[i]), 32'(vt[k].exp_b));
                chk($sformatf("vec%0d_valid[%0d]", k, i), 32'(ov[i]), 32'd1);
            end
        end

        // Load-use: count stall cycles and bubbles for 1 and 3 stall configurations
        do_reset();
        set_load_use();
        nst = '{0, 0}; nbub = '{0, 0};
        for (int c = 0; c < 5; c++) begin
            if (c == 1) begin
                ex_wr_en = 1'b0; ex_is_load = 1'b0;
                mem_wr_en = 1'b1; mem_rd = 3'd2; mem_result = 16'h5A5A;
            end
            #1;
            for (int i = 0; i < 2; i++) if (st[i]) nst[i]++;
            step();
            for (int i = 0; i < 2; i++) if (!ov[i]) nbub[i]++;
            if (c == 1) chk("lu1_out_b", 32'(ob[0]), 32'h5A5A);
            if (c == 3) chk("lu3_out_b", 32'(ob[1]), 32'h5A5A);
        end
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("lu_stall_cycles[%0d]", i), 32'(nst[i]), 32'(lsc(i)));
            chk($sformatf("lu_bubbles[%0d]", i), 32'(nbub[i]), 32'(lsc(i)));
        end

        // Flush in the second stall cycle of the 3-bubble instance
        do_reset();
        set_load_use();
        step();
        ex_wr_en = 1'b0; ex_is_load = 1'b0; flush = 1'b1;
        #1;
        chk("flush_stall", 32'(st[1]), 32'd0);
        step();
        chk("flush_bubble", 32'(ov[1]), 32'd0);
        flush = 1'b0;
        #1;
        chk("post_flush_stall", 32'(st[1]), 32'd0);
        step();
        chk("post_flush_accept", 32'(ov[1]), 32'd1);

        // Hold for 4 cycles with a valid instruction latched
        do_reset();
        in_valid = 1'b1; in_rs1 = 3'd1; in_rs2 = 3'd2; in_use_rs1 = 1'b1; in_use_rs2 = 1'b1;
        rf_busa = 16'h3333; rf_busb = 16'h4444; in_pc = 16'h1111; in_imm = 16'h2222;
        in_rd = 3'd5; in_ctrl = 12'hABC;
        step();
        in_pc = 16'h9999; rf_busa = 16'h0000; in_ctrl = 12'h001; hold = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("hold_stall", 32'(st[0]), 32'd1);
            step();
            chk("hold_pc", 32'(opc[0]), 32'h1111);
            chk("hold_a", 32'(oa[1]), 32'h3333);
            chk("hold_ctrl", 32'(octl[0]), 32'hABC);
        end
        hold = 1'b0;
        step();

        // Reset in the middle of a stall
        do_reset();
        set_load_use();
        step();
        reset = 1'b0;
        #1;
        chk("rst_stall0", 32'(st[0]), 32'd0);
        chk("rst_stall1", 32'(st[1]), 32'd0);
        step();
        chk("rst_pc", 32'(opc[1]), 32'd0);
        reset = 1'b1;
        step();

`ifdef HAZARD_STATS_EN
        // Two load-use hazards and three forwarded accepts on the 1-bubble instance
        do_reset();
        for (int r = 0; r < 2; r++) begin
            set_load_use();
            step();
            ex_wr_en = 1'b0; ex_is_load = 1'b0;
            mem_wr_en = 1'b1; mem_rd = 3'd2; mem_result = 16'h0707;
            step();
            clear_in();
            for (int c = 0; c < 3; c++) step();
        end
        in_valid = 1'b1; in_rs1 = 3'd4; in_use_rs1 = 1'b1;
        wb_wr_en = 1'b1; wb_rd = 3'd4; wb_result = 16'h4444;
        step();
        clear_in();
        step();
        chk("stat_stalls_const", 32'(s_stl[0]), 32'd2);
        chk("stat_fwds_const", 32'(s_fwd[0]), 32'd3);
`endif

        // Randomised traffic against the model
        do_reset();
        for (int n = 0; n < 400; n++) begin
            reset      = ($urandom_range(63) != 0);
            in_valid   = ($urandom_range(3) != 0);
            in_rs1     = 3'($urandom_range(7));
            in_rs2     = 3'($urandom_range(7));
            in_rd      = 3'($urandom_range(7));
            in_use_rs1 = 1'($urandom_range(1));
            in_use_rs2 = 1'($urandom_range(1));
            in_ctrl    = 12'($urandom);
            in_imm     = 16'($urandom);
            in_pc      = 16'($urandom);
            rf_busa    = 16'($urandom);
            rf_busb    = 16'($urandom);
            ex_wr_en   = 1'($urandom_range(1));
            ex_is_load = ($urandom_range(2) == 0);
            ex_rd      = 3'($urandom_range(7));
            ex_result  = 16'($urandom);
            mem_wr_en  = 1'($urandom_range(1));
            mem_rd     = 3'($urandom_range(7));
            mem_result = 16'($urandom);
            wb_wr_en   = 1'($urandom_range(1));
            wb_rd      = 3'($urandom_range(7));
            wb_result  = 16'($urandom);
            flush      = ($urandom_range(15) == 0);
            hold       = ($urandom_range(7) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
